// File: rtl/vdp_wb_arbiter.sv
// Two-master Wishbone arbiter: mgmt (master 0) and LA debug (master 1) share one slave.
// Round-robin grant held for the whole cyc; a watchdog aborts slave cycles that never ack.
module vdp_wb_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    // master 0 (mgmt)
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    // master 1 (LA debug)
    input  logic        la_cyc_i,
    input  logic        la_stb_i,
    input  logic        la_we_i,
    input  logic [3:0]  la_sel_i,
    input  logic [31:0] la_adr_i,
    input  logic [31:0] la_dat_i,
    output logic        la_ack_o,
    output logic [31:0] la_dat_o,
    // slave
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_dat_i,
    // status
    output logic [1:0]  grant_o,
    output logic [7:0]  timeout_count_o
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

    localparam logic [7:0]  WD_LIM    = 8'(TIMEOUT - 1);
    localparam logic [31:0] ABORT_DAT = 32'hDEAD_DEAD;

    state_t      state_q;
    logic        last_q;
    logic [7:0]  wd_q, wd_d;
    logic [7:0]  tcnt_q;
    logic        req0, req1, wd_hit;

    assign req0 = wbs_cyc_i & wbs_stb_i;
    assign req1 = la_cyc_i & la_stb_i;

    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = 4'h0;
        s_adr_o   = 32'h0;
        s_dat_o   = 32'h0;
        wbs_ack_o = 1'b0;
        wbs_dat_o = 32'h0;
        la_ack_o  = 1'b0;
        la_dat_o  = 32'h0;
        grant_o   = 2'b00;
        case (state_q)
            OWN0: begin
                s_cyc_o   = wbs_cyc_i;
                s_stb_o   = wbs_stb_i;
                s_we_o    = wbs_we_i;
                s_sel_o   = wbs_sel_i;
                s_adr_o   = wbs_adr_i;
                s_dat_o   = wbs_dat_i;
                wbs_ack_o = s_ack_i;
                wbs_dat_o = s_dat_i;
                grant_o   = 2'b01;
            end
            OWN1: begin
                s_cyc_o  = la_cyc_i;
                s_stb_o  = la_stb_i;
                s_we_o   = la_we_i;
                s_sel_o  = la_sel_i;
                s_adr_o  = la_adr_i;
                s_dat_o  = la_dat_i;
                la_ack_o = s_ack_i;
                la_dat_o = s_dat_i;
                grant_o  = 2'b10;
            end
            ABORT: begin
                // last_q still names the owner whose cycle is being cut
                if (last_q) begin
                    la_ack_o = 1'b1;
                    la_dat_o = ABORT_DAT;
                    grant_o  = 2'b10;
                end else begin
                    wbs_ack_o = 1'b1;
                    wbs_dat_o = ABORT_DAT;
                    grant_o   = 2'b01;
                end
            end
            default: ;
        endcase
    end

    assign wd_d   = (!s_stb_o || s_ack_i) ? 8'h00 : wd_q + 8'h01;
    // a real ack in the limit cycle wins over the abort
    assign wd_hit = s_stb_o && !s_ack_i && (wd_q == WD_LIM);

    assign timeout_count_o = tcnt_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            wd_q    <= 8'h00;
            tcnt_q  <= 8'h00;
        end else begin
            wd_q <= wd_d;
            case (state_q)
                IDLE: begin
                    if (req0 && (!req1 || last_q)) begin
                        state_q <= OWN0;
                        last_q  <= 1'b0;
                    end else if (req1) begin
                        state_q <= OWN1;
                        last_q  <= 1'b1;
                    end
                end
                OWN0: begin
                    if (wd_hit)          state_q <= ABORT;
                    else if (!wbs_cyc_i) state_q <= IDLE;
                end
                OWN1: begin
                    if (wd_hit)         state_q <= ABORT;
                    else if (!la_cyc_i) state_q <= IDLE;
                end
                ABORT: begin
                    state_q <= IDLE;
                    if (tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 8'h01;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
